// File: rtl/usb2classic_pkg.sv
// Shared definitions for the USB-to-classic-console pad output path.
package usb2classic_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned PAD_BITS_3DO        = 16;

  typedef enum logic {
    EDGE_FALL = 1'b0,
    EDGE_RISE = 1'b1
  } edge_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } frame_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous console line, plus one history
// flop so rise/fall are single-cycle pulses in the system_clock domain.
module sync_edge_detect
  import usb2classic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic system_clock,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/pad_shift_serializer.sv
// Parallel-in/serial-out stage for the 3DO pad driver: snapshots the button
// word on console latch and shifts it out MSB first on console clock edges.
module pad_shift_serializer
  import usb2classic_pkg::*;
#(
  parameter int unsigned BITS        = PAD_BITS_3DO,
  parameter int unsigned SHIFT_EDGE  = 1,
  parameter logic        FILL_BIT    = 1'b0,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic            system_clock,
  input  logic            reset_n,
  input  logic            latch,
  input  logic            clk,
  input  logic [BITS-1:0] i,
  input  logic            i_valid,
  output logic            data,
  output logic            busy,
  output logic            frame_done
);

  localparam int unsigned     CNT_W    = $clog2(BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS);
  localparam edge_sel_e       EDGE_SEL = edge_sel_e'(SHIFT_EDGE[0]);

  logic latch_s, latch_rise, latch_fall;
  logic clk_s, clk_rise, clk_fall;
  logic clk_edge, shift_ev;

  logic [BITS-1:0]  pending_q;
  logic [BITS-1:0]  shadow_q;
  logic [BITS-1:0]  sr_q;
  logic [CNT_W-1:0] bit_cnt;

  frame_state_e state_q, state_d;
  logic         done_d;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_latch_sync (
    .system_clock(system_clock),
    .reset_n     (reset_n),
    .async_in    (latch),
    .level       (latch_s),
    .rise        (latch_rise),
    .fall        (latch_fall)
  );

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_clk_sync (
    .system_clock(system_clock),
    .reset_n     (reset_n),
    .async_in    (clk),
    .level       (clk_s),
    .rise        (clk_rise),
    .fall        (clk_fall)
  );

  function automatic logic [BITS-1:0] shift_fill(input logic [BITS-1:0] v);
    logic [BITS-1:0] r;
    r[0] = FILL_BIT;
    for (int unsigned k = 1; k < BITS; k++) begin
      r[k] = v[k-1];
    end
    return r;
  endfunction

  assign clk_edge = (EDGE_SEL == EDGE_RISE) ? (clk_rise & clk_s) : (clk_fall & ~clk_s);
  // Latch level and the latch-fall cycle both own the register, so a
  // coincident clock edge is never counted as a shift.
  assign shift_ev = clk_edge & ~latch_s & ~latch_fall;

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (latch_s) begin
      state_d = ST_LOAD;
    end else if (latch_fall) begin
      state_d = ST_SHIFT;
    end else if (shift_ev && (state_q == ST_SHIFT) && (bit_cnt == CNT_LAST)) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      shadow_q   <= '0;
      sr_q       <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_d;

      if (i_valid) begin
        pending_q <= i;
      end

      // A word arriving on the latch-rise cycle bypasses pending so the
      // console sees it in this frame rather than the next.
      if (latch_rise && i_valid) begin
        shadow_q <= i;
      end else if (latch_s) begin
        shadow_q <= pending_q;
      end

      if (latch_s) begin
        sr_q <= shadow_q;
      end else if (shift_ev) begin
        sr_q <= shift_fill(sr_q);
      end

      if (latch_s || latch_fall) begin
        bit_cnt <= '0;
      end else if (shift_ev && (bit_cnt != CNT_FULL)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign data = sr_q[BITS-1];
  assign busy = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_pad_shift_serializer.sv
// Scoreboard bench for pad_shift_serializer: rising-edge and falling-edge
// instances share stimulus; expected serial bits are queued at word load.
module tb_pad_shift_serializer;

  localparam int unsigned BITS = 16;

  logic            system_clock;
  logic            reset_n;
  logic            latch;
  logic            clk;
  logic [BITS-1:0] i;
  logic            i_valid;
  logic            data, busy, frame_done;
  logic            data_f, busy_f, frame_done_f;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt   = 0;
  int unsigned done_cnt_f = 0;
  logic        sb[$];
  logic        sb_f[$];
  logic        last_f;

  pad_shift_serializer #(
    .BITS       (BITS),
    .SHIFT_EDGE (1),
    .FILL_BIT   (1'b0),
    .SYNC_STAGES(2)
  ) dut (
    .system_clock(system_clock),
    .reset_n     (reset_n),
    .latch       (latch),
    .clk         (clk),
    .i           (i),
    .i_valid     (i_valid),
    .data        (data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  pad_shift_serializer #(
    .BITS       (BITS),
    .SHIFT_EDGE (0),
    .FILL_BIT   (1'b0),
    .SYNC_STAGES(2)
  ) dut_f (
    .system_clock(system_clock),
    .reset_n     (reset_n),
    .latch       (latch),
    .clk         (clk),
    .i           (i),
    .i_valid     (i_valid),
    .data        (data_f),
    .busy        (busy_f),
    .frame_done  (frame_done_f)
  );

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  always @(negedge system_clock) begin
    if (frame_done === 1'b1)   done_cnt++;
    if (frame_done_f === 1'b1) done_cnt_f++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sys_wait(input int unsigned n);
    repeat (n) @(posedge system_clock);
    #3;
  endtask

  task automatic push_word(input logic [BITS-1:0] w);
    for (int k = BITS - 1; k >= 0; k--) begin
      sb.push_back(w[k]);
      sb_f.push_back(w[k]);
    end
    sb.push_back(1'b0);
    sb_f.push_back(1'b0);
  endtask

  task automatic check_data(input string tag);
    logic exp;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb"}, 32'(sb.size()), 32'd1);
    end else begin
      exp = sb.pop_front();
      check_eq(tag, 32'(data), 32'(exp));
    end
  endtask

  task automatic check_data_f(input string tag);
    if (sb_f.size() == 0) begin
      check_eq({tag, "_sb"}, 32'(sb_f.size()), 32'd1);
    end else begin
      last_f = sb_f.pop_front();
      check_eq(tag, 32'(data_f), 32'(last_f));
    end
  endtask

  task automatic load_word(input logic [BITS-1:0] w);
    i       = w;
    i_valid = 1'b1;
    sys_wait(1);
    i_valid = 1'b0;
  endtask

  task automatic latch_pulse();
    latch = 1'b1;
    sys_wait(6);
    latch = 1'b0;
    sys_wait(6);
  endtask

  task automatic clk_pulse();
    clk = 1'b1;
    sys_wait(6);
    clk = 1'b0;
    sys_wait(6);
  endtask

  task automatic run_frame(input string tag, input int unsigned first, input int unsigned n);
    int unsigned d0;
    for (int unsigned k = first; k < first + n; k++) begin
      d0 = done_cnt;
      if (k < BITS) check_eq($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
      clk_pulse();
      check_data($sformatf("%s_bit%0d", tag, k + 1));
      check_eq($sformatf("%s_done%0d", tag, k + 1), done_cnt - d0,
               (k == BITS - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    latch   = 1'b0;
    clk     = 1'b0;
    i       = '0;
    i_valid = 1'b0;
    sys_wait(3);
    check_eq("rst_data", 32'(data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    sys_wait(2);

    // 1) basic frame
    load_word(16'hA5C3);
    push_word(16'hA5C3);
    latch_pulse();
    check_data("t1_bit0");
    run_frame("t1", 0, BITS);
    check_eq("t1_busy_end", 32'(busy), 32'd0);
    check_eq("t1_cnt", 32'(dut.bit_cnt), 32'd16);

    // 2) overrun edges shift fill, no extra frame_done
    for (int k = 0; k < 4; k++) sb.push_back(1'b0);
    run_frame("t2", BITS, 4);
    check_eq("t2_cnt", 32'(dut.bit_cnt), 32'd16);
    check_eq("t2_busy", 32'(busy), 32'd0);

    // 3) new word mid-frame does not tear current frame
    sb.delete();
    load_word(16'h0000);
    push_word(16'h0000);
    latch_pulse();
    check_data("t3_bit0");
    run_frame("t3a", 0, 5);
    load_word(16'hFFFF);
    run_frame("t3b", 5, BITS - 5);
    push_word(16'hFFFF);
    latch_pulse();
    check_data("t3c_bit0");
    run_frame("t3c", 0, BITS);

    // 4) latch reasserted mid-frame aborts
    sb.delete();
    load_word(16'hF00F);
    push_word(16'hF00F);
    latch_pulse();
    check_data("t4_bit0");
    run_frame("t4", 0, 8);
    begin
      int unsigned d0;
      d0 = done_cnt;
      latch = 1'b1;
      sys_wait(6);
      sb.delete();
      sb.push_back(1'b1);
      check_eq("t4_abort_busy", 32'(busy), 32'd0);
      check_eq("t4_abort_done", done_cnt - d0, 32'd0);
      check_data("t4_abort_data");
      latch = 1'b0;
      sys_wait(6);
    end

    // 5) clk edges during load and coincident with latch rise
    load_word(16'h8000);
    latch = 1'b1;
    sys_wait(6);
    for (int k = 0; k < 3; k++) clk_pulse();
    check_eq("t5_cnt_load", 32'(dut.bit_cnt), 32'd0);
    check_eq("t5_busy_load", 32'(busy), 32'd0);
    check_eq("t5_data_load", 32'(data), 32'd1);
    latch = 1'b0;
    sys_wait(6);
    check_eq("t5_busy_shift", 32'(busy), 32'd1);
    clk   = 1'b1;
    latch = 1'b1;
    sys_wait(6);
    check_eq("t5_cnt_coinc", 32'(dut.bit_cnt), 32'd0);
    check_eq("t5_busy_coinc", 32'(busy), 32'd0);
    check_eq("t5_data_coinc", 32'(data), 32'd1);
    clk = 1'b0;
    sys_wait(6);
    latch = 1'b0;
    sys_wait(6);

    // 6) async reset mid-frame, then falling-edge instance rerun
    sb.delete();
    load_word(16'hA5C3);
    push_word(16'hA5C3);
    latch_pulse();
    check_data("t6_bit0");
    clk_pulse();
    check_data("t6_bit1");
    clk_pulse();
    check_data("t6_bit2");
    check_eq("t6_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_data", 32'(data), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_done", 32'(frame_done), 32'd0);
    sys_wait(2);
    reset_n = 1'b1;
    sys_wait(2);

    sb.delete();
    sb_f.delete();
    load_word(16'hA5C3);
    push_word(16'hA5C3);
    latch_pulse();
    check_data("t6r_bit0");
    check_data_f("t6f_bit0");
    begin
      int unsigned d0;
      d0 = done_cnt_f;
      for (int unsigned k = 0; k < BITS; k++) begin
        clk = 1'b1;
        sys_wait(6);
        check_eq($sformatf("t6f_hold%0d", k), 32'(data_f), 32'(last_f));
        clk = 1'b0;
        sys_wait(6);
        check_data($sformatf("t6r_bit%0d", k + 1));
        check_data_f($sformatf("t6f_bit%0d", k + 1));
      end
      check_eq("t6f_done", done_cnt_f - d0, 32'd1);
      check_eq("t6f_busy_end", 32'(busy_f), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
